// File: rtl/instr_encoder.sv
// instr_encoder
//   Streaming RV32 instruction encoder for the program-load path. Accepts a
//   field bundle (format, registers, funct, immediate) over valid/ready,
//   packs it into a 32-bit instruction word with immediates placed exactly
//   where the decode-side sign extender reads them, and emits it with an
//   incrementing instruction-memory byte address. Bundles with an illegal
//   format or an out-of-range immediate are dropped, pulse err and bump a
//   saturating err_count.
//
// Parameters
//   ADDR_W     width of out_addr
//   BASE_ADDR  out_addr after reset (multiple of 4)
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready is combinational)
//   fmt               0=R 1=I-ALU 2=LW 3=SW 4=BEQ 5=JAL 6=JALR 7=illegal
//   rd, rs1, rs2      register numbers
//   funct3, funct7    function fields (funct3: R/I-ALU, funct7: R)
//   imm               signed immediate, decode-side units
//   out_valid/out_ready output handshake
//   out_instr         encoded instruction word
//   out_addr          byte address of out_instr
//   err               one-cycle pulse after a rejected bundle is accepted
//   err_count         rejected bundles, saturating at 255
module instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_LW   = 3'd2,
    FMT_SW   = 3'd3,
    FMT_BEQ  = 3'd4,
    FMT_JAL  = 3'd5,
    FMT_JALR = 3'd6,
    FMT_ILL  = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  fmt_e              w_fmt;
  logic              w_imm12_ok;
  logic              w_imm20_ok;
  logic [31:0]       w_word;
  logic              w_bad;
  logic              w_advance;
  logic              w_accept;
  logic              w_good;

  logic              r_s1_valid;
  logic [31:0]       r_s1_instr;
  logic              r_s2_valid;
  logic [31:0]       r_s2_instr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [7:0]        r_err_count;

  assign w_fmt = fmt_e'(fmt);

  // An immediate fits N signed bits when every bit above N-1 copies the sign.
  assign w_imm12_ok = (imm[31:11] == {21{imm[11]}});
  assign w_imm20_ok = (imm[31:19] == {13{imm[19]}});

  always_comb begin
    w_word = '0;
    w_bad  = 1'b0;
    unique case (w_fmt)
      FMT_R: begin
        w_word = {funct7, rs2, rs1, funct3, rd, OP_R};
      end
      FMT_I: begin
        w_word = {imm[11:0], rs1, funct3, rd, OP_I};
        w_bad  = !w_imm12_ok;
      end
      FMT_LW: begin
        w_word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
        w_bad  = !w_imm12_ok;
      end
      FMT_SW: begin
        w_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
        w_bad  = !w_imm12_ok;
      end
      FMT_BEQ: begin
        // imm is a halfword offset, so imm[3:0] lands in [11:8] directly.
        w_word = {imm[11], imm[9:4], rs2, rs1, 3'b000, imm[3:0], imm[10], OP_BR};
        w_bad  = !w_imm12_ok;
      end
      FMT_JAL: begin
        w_word = {imm[19], imm[9:0], imm[10], imm[18:11], rd, OP_JAL};
        w_bad  = !w_imm20_ok;
      end
      FMT_JALR: begin
        w_word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        w_bad  = !w_imm12_ok;
      end
      FMT_ILL: begin
        w_bad  = 1'b1;
      end
      default: begin
        w_bad  = 1'b1;
      end
    endcase
  end

  // Whole pipe moves together: it advances whenever the output register is
  // empty or being drained, otherwise both stages hold.
  assign w_advance = !r_s2_valid || out_ready;
  assign w_accept  = in_valid && w_advance;
  assign w_good    = w_accept && !w_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_instr  <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_instr  <= '0;
      r_addr      <= ADDR_W'(BASE_ADDR);
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err <= w_accept && w_bad;
      if (w_accept && w_bad && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end

      // Address tracks the output handshake, so an item entering S2 on the
      // same edge already sees the incremented value.
      if (r_s2_valid && out_ready) begin
        r_addr <= r_addr + ADDR_W'(4);
      end

      if (w_advance) begin
        r_s1_valid <= w_good;
        if (w_good) begin
          r_s1_instr <= w_word;
        end
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_instr <= r_s1_instr;
        end
      end
    end
  end

  assign in_ready  = w_advance;
  assign out_valid = r_s2_valid;
  assign out_instr = r_s2_instr;
  assign out_addr  = r_addr;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed encodings, rejects, backpressure,
// mid-stream reset, address wrap, error saturation and randomized traffic,
// checked through a scoreboard against a field-placement reference model.
module tb_instr_encoder;

  localparam int unsigned AW   = 4;
  localparam int unsigned BASE = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    fmt = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic [31:0]   imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err;
  logic [7:0]    err_count;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int unsigned addr;
    int          f;
    int          v;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned next_addr = BASE;
  bit          ready_rand = 1'b0;
  bit          ready_fix  = 1'b1;

  // ---------------- reference model ----------------
  function automatic bit in_range(input int f, input int v);
    case (f)
      0:             return 1'b1;
      1, 2, 3, 4, 6: return (v >= -2048) && (v <= 2047);
      5:             return (v >= -524288) && (v <= 524287);
      default:       return 1'b0;
    endcase
  endfunction

  function automatic int unsigned fld(input int v, input int hi, input int lo);
    int unsigned u;
    u = int'(v);
    return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic logic [31:0] ref_encode(input int f, input int r_d, input int r1,
                                             input int r2, input int f3, input int f7,
                                             input int v);
    int unsigned d, a, b, w;
    d = int'(r_d) << 7;
    a = int'(r1) << 15;
    b = int'(r2) << 20;
    case (f)
      0: w = (int'(f7) << 25) + b + a + (int'(f3) << 12) + d + 32'h33;
      1: w = (fld(v, 11, 0) << 20) + a + (int'(f3) << 12) + d + 32'h13;
      2: w = (fld(v, 11, 0) << 20) + a + (32'd2 << 12) + d + 32'h03;
      3: w = (fld(v, 11, 5) << 25) + b + a + (32'd2 << 12) + (fld(v, 4, 0) << 7) + 32'h23;
      4: w = (fld(v, 11, 11) << 31) + (fld(v, 9, 4) << 25) + b + a
             + (fld(v, 3, 0) << 8) + (fld(v, 10, 10) << 7) + 32'h63;
      5: w = (fld(v, 19, 19) << 31) + (fld(v, 9, 0) << 21) + (fld(v, 10, 10) << 20)
             + (fld(v, 18, 11) << 12) + d + 32'h6F;
      6: w = (fld(v, 11, 0) << 20) + a + d + 32'h67;
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic int sext(input int unsigned v, input int n);
    int unsigned m;
    m = 32'd1 << (n - 1);
    return int'((v ^ m) - m);
  endfunction

  // Decode-side immediate extractor used for the round-trip check.
  function automatic int ref_decode(input int f, input logic [31:0] w);
    int unsigned u;
    u = w;
    case (f)
      1, 2, 6: return sext(u >> 20, 12);
      3:       return sext(((u >> 25) << 5) | ((u >> 7) & 31), 12);
      4:       return sext((((u >> 31) & 1) << 11) | (((u >> 7) & 1) << 10)
                           | (((u >> 25) & 63) << 4) | ((u >> 8) & 15), 12);
      5:       return sext((((u >> 31) & 1) << 19) | (((u >> 12) & 255) << 11)
                           | (((u >> 20) & 1) << 10) | ((u >> 21) & 1023), 20);
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  initial begin : ready_drv
    forever begin
      @(negedge clk);
      out_ready = ready_rand ? (($urandom % 4) != 0) : ready_fix;
    end
  end

  task automatic send(input int f, input int r_d, input int r1, input int r2,
                      input int f3, input int f7, input int v, input bit use_c,
                      input logic [31:0] cw, input int budget, output bit ok);
    exp_t e;
    @(negedge clk);
    fmt = 3'(f); rd = 5'(r_d); rs1 = 5'(r1); rs2 = 5'(r2);
    funct3 = 3'(f3); funct7 = 7'(f7); imm = 32'(v);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      if (in_range(f, v)) begin
        e.instr = use_c ? cw : ref_encode(f, r_d, r1, r2, f3, f7, v);
        e.addr  = next_addr;
        e.f     = f;
        e.v     = v;
        sb.push_back(e);
        next_addr = (next_addr + 4) % (32'd1 << AW);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic put(input int f, input int r_d, input int r1, input int r2,
                     input int f3, input int f7, input int v, input bit use_c,
                     input logic [31:0] cw);
    bit ok;
    send(f, r_d, r1, r2, f3, f7, v, use_c, cw, 60, ok);
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic put_rand(input int f, input int v);
    put(f, int'($urandom % 32), int'($urandom % 32), int'($urandom % 32),
        int'($urandom % 8), int'($urandom % 128), v, 1'b0, '0);
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    #3;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    next_addr = BASE;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit prev_rst;
    bit exp_err;
    int exp_cnt;
    prev_rst = 1'b0;
    exp_err  = 1'b0;
    exp_cnt  = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_rst = 1'b1;
        exp_err  = 1'b0;
        exp_cnt  = 0;
        continue;
      end
      if (prev_rst) begin
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", 32'(out_addr), BASE);
        prev_rst = 1'b0;
      end
      check("err", 32'(err), 32'(exp_err));
      check("err_count", 32'(err_count), 32'(exp_cnt));
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got instr 0x%08h addr %0d, expected no output",
                   out_instr, out_addr);
        end else begin
          check("out_instr", out_instr, sb[0].instr);
          check("out_addr", 32'(out_addr), sb[0].addr);
          if (out_ready) begin
            if (sb[0].f != 0) check("roundtrip_imm", ref_decode(sb[0].f, out_instr), sb[0].v);
            void'(sb.pop_front());
          end
        end
      end
      exp_err = in_valid && in_ready && !in_range(int'(fmt), $signed(imm));
      if (exp_err && exp_cnt < 255) exp_cnt++;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    bit ok;
    int acc;
    int bvals[8];
    bvals = '{2047, 2048, -2048, -2049, 524287, 524288, -524288, -524289};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    ready_fix = 1'b1;

    // Rejects: out-of-range LW, illegal format; next good item keeps BASE.
    put(2, 5, 2, 0, 0, 0, 2048, 1'b0, '0);
    put(7, 1, 1, 1, 0, 0, 0, 1'b0, '0);
    @(negedge clk);
    #2;
    check("err_count_two", 32'(err_count), 32'd2);

    // Directed encodings from known-good words.
    put(0, 1, 2, 3, 0, 32'h20, 0, 1'b1, 32'h403100B3);
    put(2, 5, 2, 0, 0, 0, 8, 1'b1, 32'h00812283);
    put(3, 0, 2, 6, 0, 0, -4, 1'b1, 32'hFE612E23);
    put(4, 0, 1, 2, 0, 0, 4, 1'b1, 32'h00208463);
    put(5, 1, 0, 0, 0, 0, -1, 1'b1, 32'hFFFFF0EF);
    drain();

    // Backpressure: only two fit with out_ready held low.
    ready_fix = 1'b0;
    @(negedge clk);
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      send(1, i + 1, 3, 0, 4, 0, 100 + i, 1'b0, '0, 4, ok);
      if (ok) acc++;
    end
    #1;
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    ready_fix = 1'b1;
    put(1, 3, 3, 0, 4, 0, 102, 1'b0, '0);
    drain();

    // Address wrap with a 4-bit address.
    for (int i = 0; i < 5; i++) put_rand(6, i * 16 - 30);
    drain();

    // Reset with both stages full discards the held items.
    ready_fix = 1'b0;
    @(negedge clk);
    put_rand(0, 0);
    put_rand(1, 7);
    do_reset();
    ready_fix = 1'b1;
    put_rand(5, -524288);
    drain();

    // Randomized traffic with random output backpressure.
    ready_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int f, v;
      f = int'($urandom % 8);
      case ($urandom % 8)
        0:       v = bvals[$urandom % 8];
        1:       v = int'($urandom);
        2:       v = int'($urandom_range(0, 1048575)) - 524288;
        default: v = int'($urandom_range(0, 4095)) - 2048;
      endcase
      put_rand(f, v);
      if (($urandom % 5) == 0) @(negedge clk);
    end
    ready_rand = 1'b0;
    ready_fix  = 1'b1;
    drain();

    // Error counter saturation; err keeps pulsing at 255.
    for (int i = 0; i < 260; i++) put_rand(7, 0);
    put_rand(2, 4096);
    @(negedge clk);
    #2;
    check("err_count_sat", 32'(err_count), 32'd255);
    put_rand(2, 12);
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
